// File: rtl/pixel_stream_out.sv
// pixel_stream_out: buffers active pixels of a strobed video stream into a FIFO and
// presents them on a valid/ready output with start-of-frame and end-of-line flags.
// Latency: 2 clk from pixel strobe to m_valid on an empty FIFO.
// Backpressure: m_ready low holds the head word; a push onto a full FIFO is lost,
// sets sticky overflow and drops pixels until the next frame sync.
//
// Ports:
//   clk, reset          clock (rising edge), asynchronous active-high reset
//   p_tick              pixel strobe; hsync/vsync/rgb are sampled only when high
//   hsync, vsync, rgb   end-of-line marker, end-of-frame marker, 12-bit colour
//   m_data/m_sof/m_eol  head word colour, first pixel of frame, last pixel of line
//   m_valid, m_ready    output handshake; pop on m_valid & m_ready
//   overflow            sticky, a pixel was lost (cleared only by reset)
//   frame_cnt           completed frames, wraps at 256
// Optional (macro PIXEL_STREAM_OUT_CRC_EN):
//   frame_crc, crc_valid  CRC-16-CCITT of the popped words of each frame, pulsed
//                         after the last word of the last active line is popped

module pixel_stream_out #(
  parameter int ACTIVE_W   = 128,
  parameter int ACTIVE_H   = 64,
  parameter int FIFO_DEPTH = 16,
  parameter int COL_W      = 9,
  parameter int ROW_W      = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        p_tick,
  input  logic        hsync,
  input  logic        vsync,
  input  logic [11:0] rgb,
  output logic [11:0] m_data,
  output logic        m_sof,
  output logic        m_eol,
  output logic        m_valid,
  input  logic        m_ready,
  output logic        overflow,
  output logic [7:0]  frame_cnt
`ifdef PIXEL_STREAM_OUT_CRC_EN
  ,
  output logic [15:0] frame_crc,
  output logic        crc_valid
`endif
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(ACTIVE_W - 1);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ACTIVE_H - 1);
  localparam logic [AW:0]      DEPTH_C  = (AW + 1)'(FIFO_DEPTH);

  // FIFO entry: {rgb, sof, eol}; the CRC build adds a "last word of frame" flag on top
`ifdef PIXEL_STREAM_OUT_CRC_EN
  localparam int ENT_W = 15;
`else
  localparam int ENT_W = 14;
`endif

  typedef enum logic [1:0] {SYNC, STREAM, DROP} state_t;

  state_t           state_q, state_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic             push_vld_q, push_vld_d;
  logic [ENT_W-1:0] push_ent_q, push_ent_d;
  logic [ENT_W-1:0] mem_q [FIFO_DEPTH];
  logic [ENT_W-1:0] mem_d [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic [7:0]       fcnt_q, fcnt_d;

  logic             frame_sync;
  logic             active;
  logic             pix_sof, pix_eol, pix_last;
  logic             full, pop, push_try, wr_en, push_lost;
  logic [ENT_W-1:0] head;

  assign frame_sync = p_tick & hsync & vsync;
  assign active     = (col_q <= LAST_COL) && (row_q <= LAST_ROW);
  assign pix_sof    = (col_q == '0) && (row_q == '0);
  assign pix_eol    = (col_q == LAST_COL);
  assign pix_last   = pix_eol && (row_q == LAST_ROW);

  assign head       = mem_q[rd_ptr_q];
  assign m_valid    = (cnt_q != '0);
  assign full       = (cnt_q == DEPTH_C);
  assign pop        = m_valid & m_ready;
  // A pixel registered while streaming is still discarded if the FSM has
  // meanwhile fallen into DROP, so nothing enters the FIFO during DROP.
  assign push_try   = push_vld_q && (state_q == STREAM);
  assign wr_en      = push_try && (!full || pop);
  assign push_lost  = push_try && full && !pop;

  assign m_data     = m_valid ? head[13:2] : 12'h000;
  assign m_sof      = m_valid & head[1];
  assign m_eol      = m_valid & head[0];
  assign overflow   = ovf_q;
  assign frame_cnt  = fcnt_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      SYNC:    if (frame_sync) state_d = STREAM;
      STREAM:  if (push_lost)  state_d = DROP;
      DROP:    if (frame_sync) state_d = STREAM;
      default: state_d = SYNC;
    endcase
  end

  always_comb begin
    col_d      = col_q;
    row_d      = row_q;
    push_vld_d = 1'b0;
    push_ent_d = push_ent_q;
    if (p_tick) begin
      push_vld_d = (state_q == STREAM) && active;
`ifdef PIXEL_STREAM_OUT_CRC_EN
      push_ent_d = {pix_last, rgb, pix_sof, pix_eol};
`else
      push_ent_d = {rgb, pix_sof, pix_eol};
`endif
      if (hsync) begin
        col_d = '0;
        row_d = vsync ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (wr_en) begin
      mem_d[wr_ptr_q] = push_ent_q;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({wr_en, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_comb begin
    ovf_d  = ovf_q | push_lost;
    fcnt_d = fcnt_q;
    if (frame_sync && (state_q != SYNC)) begin
      fcnt_d = fcnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= SYNC;
      col_q      <= '0;
      row_q      <= '0;
      push_vld_q <= 1'b0;
      push_ent_q <= '0;
      mem_q      <= '{default: '0};
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
      fcnt_q     <= '0;
    end else begin
      state_q    <= state_d;
      col_q      <= col_d;
      row_q      <= row_d;
      push_vld_q <= push_vld_d;
      push_ent_q <= push_ent_d;
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
      fcnt_q     <= fcnt_d;
    end
  end

`ifdef PIXEL_STREAM_OUT_CRC_EN
  // CRC-16-CCITT, polynomial 0x1021, 12 data bits shifted in MSB first
  function automatic logic [15:0] crc12(input logic [15:0] c, input logic [11:0] d);
    logic [15:0] r;
    logic        fb;
    r = c;
    for (int i = 11; i >= 0; i--) begin
      fb = r[15] ^ d[i];
      r  = {r[14:0], 1'b0};
      if (fb) r = r ^ 16'h1021;
    end
    return r;
  endfunction

  logic [15:0] crc_run_q, crc_run_d;
  logic [15:0] frame_crc_q, frame_crc_d;
  logic        crc_valid_q, crc_valid_d;
  logic [15:0] crc_next;

  // A start-of-frame word restarts the running CRC and is folded in itself.
  assign crc_next = crc12(m_sof ? 16'hFFFF : crc_run_q, m_data);

  always_comb begin
    crc_run_d   = crc_run_q;
    frame_crc_d = frame_crc_q;
    crc_valid_d = 1'b0;
    if (pop) begin
      crc_run_d = crc_next;
      if (head[14]) begin
        frame_crc_d = crc_next;
        crc_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      crc_run_q   <= '0;
      frame_crc_q <= '0;
      crc_valid_q <= 1'b0;
    end else begin
      crc_run_q   <= crc_run_d;
      frame_crc_q <= frame_crc_d;
      crc_valid_q <= crc_valid_d;
    end
  end

  assign frame_crc = frame_crc_q;
  assign crc_valid = crc_valid_q;
`endif

endmodule
